count_uart_tx: RTL and testbench
================================

Name: count_uart_tx

Overview:
Downstream consumer of the 4-bit counter's count bus, running in the same clock domain. It detects every change of the count value and transmits that value over UART 8N1 as one ASCII hex character, optionally followed by CR LF. It gives the board a visible serial trace of the counter and feeds the on-chip UART pin.

Parameters:
CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); must be >= 2; benches override it to 4.
SEND_NEWLINE, 1, 1 = append 0x0D 0x0A after each hex character; 0 = hex character only.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
count  input  4  counter value, synchronous to clk
tx  output  1  UART serial out; idle high, LSB first
busy  output  1  high while a frame (char plus optional CR LF) is in progress
overrun  output  1  one-cycle pulse when a not-yet-sent pending value is overwritten

Behaviour:
- Reset (async assert, all regs): tx=1, busy=0, overrun=0.
  - count_q=0, prev=0, pending=0, pending_valid=0.
  - FSM=IDLE, bit/baud/byte counters=0.
- Reset mid-frame: tx returns to 1 at once. No partial frame resumes after release.
- Input stage: count_q <= count every cycle; no synchroniser, same domain.
- Change detect: if count_q != prev:
  - prev <= count_q, pending <= count_q, pending_valid <= 1.
  - If pending_valid was already 1 and the FSM is not taking it this cycle, overrun=1 for that cycle.
- Simultaneous take and new change: the set wins, so pending_valid stays 1 with the new value.
- First change after reset is measured against prev=0. A nonzero count at reset release is sent; a count of 0 sends nothing.
- Wrap 15->0 is a normal change and sends '0'.
- ASCII map: 0-9 -> 0x30-0x39; 10-15 -> 0x41-0x46 (uppercase).
- FSM states: IDLE, START, DATA, STOP, NEXT.
  - IDLE: if pending_valid, load shift reg with ASCII(pending), clear pending_valid, byte_idx=0, go to START, busy=1.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles -> NEXT.
  - NEXT: if SEND_NEWLINE and byte_idx<2, load 0x0D (idx 0) or 0x0A (idx 1), increment byte_idx, go to START. Otherwise go to IDLE with busy=0.
- NEXT takes exactly 1 cycle. Output tx is registered (glitch-free).
- Latency: a count change sampled into count_q at edge E0 sets pending at E1. The FSM enters START at E2, so tx falls after E2.
- busy timing: rises at the same edge tx falls, and is high for B*(10*CLKS_PER_BIT+1) cycles, where B = number of bytes in the frame (3 if SEND_NEWLINE, else 1). busy=0 for at least 1 cycle between frames.
- Buffering: one pending slot only. Intermediate values are lost; the latest value is always sent.

Test Plan:
1. rst high for 20 cycles, count=0, then released and held at 0 for 500 cycles -> tx=1, busy=0, overrun=0 throughout.
2. CLKS_PER_BIT=4, SEND_NEWLINE=1, count 0->5 -> decoded bytes 0x35, 0x0D, 0x0A; each bit 4 cycles; busy high 123 cycles; tx falls 2 edges after count_q updates.
3. count 9->10 -> byte 0x41; after idle, count 15->0 -> byte 0x30 (wrap sent).
4. count 0->1, then 2 and 3 applied 10 cycles apart during the '1' frame -> frames '1' then '3' only; overrun pulses exactly once (when 3 overwrites 2).
5. rst asserted during DATA bit 3 of a frame -> tx=1 and busy=0 without waiting for a clock edge. After release with count=7: one '7' frame is sent; with count=0: nothing is sent.
6. SEND_NEWLINE=0, count 3->12 -> single byte 0x43; busy high 41 cycles; no 0x0D or 0x0A emitted.

Source files
------------

// File: rtl/count_uart_tx.sv
// Sends every change of the 4-bit count as an ASCII hex character over UART 8N1, with an optional CR LF after it.
// Latency: a change registered into count_q at edge E0 sets pending at E1, and the start bit begins at E2.
// Backpressure: one pending slot; a newer value overwrites an unsent one and pulses overrun.
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter bit SEND_NEWLINE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    count_q, prev_q, pend_q;
    logic          pend_vld_q;
    logic [7:0]    byte_q, byte_d;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [1:0]    idx_q, idx_d;
    logic          tx_q, tx_d;
    logic          ov_q;
    logic          chg, take, baud_done;

    // 0-9 map to '0'-'9' and 10-15 map to 'A'-'F'
    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        if (v < 4'd10) return 8'h30 + {4'h0, v};
        return 8'h37 + {4'h0, v};
    endfunction

    assign chg       = (count_q != prev_q);
    assign take      = (state_q == IDLE) && pend_vld_q;
    assign baud_done = (baud_q == BAUD_LAST);

    // Input register, change detect and the single pending slot (a new value beats a same-cycle take)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 4'd0;
            prev_q     <= 4'd0;
            pend_q     <= 4'd0;
            pend_vld_q <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            count_q <= count;
            ov_q    <= chg && pend_vld_q && !take;
            if (chg) begin
                prev_q     <= count_q;
                pend_q     <= count_q;
                pend_vld_q <= 1'b1;
            end else if (take) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    // State register and transmit datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            byte_q  <= 8'h00;
            bit_q   <= 3'd0;
            baud_q  <= '0;
            idx_q   <= 2'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic: bit timing, byte sequencing and CR LF insertion
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    state_d = START;
                    byte_d  = hex_ascii(pend_q);
                    idx_d   = 2'd0;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = NEXT;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            NEXT: begin
                if (SEND_NEWLINE && (idx_q < 2'd2)) begin
                    byte_d  = (idx_q == 2'd0) ? 8'h0D : 8'h0A;
                    idx_d   = idx_q + 2'd1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: the line level is precomputed from the next state so tx comes straight from a flop
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy    = (state_q != IDLE);
        tx      = tx_q;
        overrun = ov_q;
    end

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: two instances (with and without CR LF) share clock, reset and count.
// A frame-position model predicts tx/busy/overrun every cycle; a UART decoder collects bytes for directed checks.
module tb_count_uart_tx;

    localparam int C        = 4;
    localparam int BYTE_CYC = 10 * C + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count = 4'd0;
    logic       tx0, busy0, ov0, tx1, busy1, ov1;

    always #5 clk = ~clk;

    count_uart_tx #(.CLKS_PER_BIT(C), .SEND_NEWLINE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .count(count), .tx(tx0), .busy(busy0), .overrun(ov0));
    count_uart_tx #(.CLKS_PER_BIT(C), .SEND_NEWLINE(1'b0)) dut1 (
        .clk(clk), .rst(rst), .count(count), .tx(tx1), .busy(busy1), .overrun(ov1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame = list of bytes; each byte is C low, 8*C data, C high, 1 gap cycle.
    logic [3:0] m_cq [2], m_prev [2], m_pend [2];
    logic       m_pv [2], m_ov [2];
    int         m_pos [2];
    logic [7:0] m_ch [2];
    logic       m_take, m_chg;

    function automatic logic [7:0] hexch(input logic [3:0] v);
        return (v < 4'd10) ? 8'h30 + 8'(v) : 8'h41 + 8'(v) - 8'd10;
    endfunction

    function automatic int frame_len(input int i);
        return (i == 0) ? 3 * BYTE_CYC : BYTE_CYC;
    endfunction

    function automatic logic exp_tx(input int i);
        int b, o;
        logic [7:0] by;
        if (m_pos[i] < 0) return 1'b1;
        b  = m_pos[i] / BYTE_CYC;
        o  = m_pos[i] % BYTE_CYC;
        by = (b == 0) ? m_ch[i] : (b == 1) ? 8'h0D : 8'h0A;
        if (o < C) return 1'b0;
        if (o < 9 * C) return by[(o - C) / C];
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cq[i] = 4'd0; m_prev[i] = 4'd0; m_pend[i] = 4'd0;
                m_pv[i] = 1'b0; m_ov[i] = 1'b0; m_pos[i] = -1; m_ch[i] = 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_take = (m_pos[i] < 0) && m_pv[i];
                m_chg  = (m_cq[i] != m_prev[i]);
                if (m_pos[i] >= 0) begin
                    m_pos[i]++;
                    if (m_pos[i] == frame_len(i)) m_pos[i] = -1;
                end else if (m_take) begin
                    m_pos[i] = 0;
                    m_ch[i]  = hexch(m_pend[i]);
                end
                m_ov[i] = m_chg && m_pv[i] && !m_take;
                if (m_chg) begin
                    m_prev[i] = m_cq[i];
                    m_pend[i] = m_cq[i];
                    m_pv[i]   = 1'b1;
                end else if (m_take) begin
                    m_pv[i] = 1'b0;
                end
                m_cq[i] = count;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("tx0 model",   tx0,   exp_tx(0));
            check("busy0 model", busy0, m_pos[0] >= 0);
            check("ov0 model",   ov0,   m_ov[0]);
            check("tx1 model",   tx1,   exp_tx(1));
            check("busy1 model", busy1, m_pos[1] >= 0);
            check("ov1 model",   ov1,   m_ov[1]);
        end
    end

    // ---------------- UART decoder and overrun counters ----------------
    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];
    int         dcnt [2];
    logic       dact [2];
    logic [7:0] dsh [2];
    int         ovc [2];
    logic       dt;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                dact[i] = 1'b0; dcnt[i] = 0; dsh[i] = 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                dt = (i == 0) ? tx0 : tx1;
                ovc[i] += (i == 0) ? int'(ov0) : int'(ov1);
                if (!dact[i]) begin
                    if (dt == 1'b0) begin
                        dact[i] = 1'b1;
                        dcnt[i] = 0;
                    end
                end else begin
                    dcnt[i]++;
                    if (dcnt[i] > C && dcnt[i] < 9 * C && (dcnt[i] % C) == C / 2)
                        dsh[i][(dcnt[i] - C) / C] = dt;
                    if (dcnt[i] == 9 * C + C / 2) begin
                        if (i == 0) rx0.push_back(dsh[i]);
                        else        rx1.push_back(dsh[i]);
                        dact[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_rx();
        rx0.delete();
        rx1.delete();
        ovc[0] = 0;
        ovc[1] = 0;
    endtask

    task automatic wait_quiet();
        int idle = 0;
        int k = 0;
        repeat (5) @(posedge clk);
        while (idle < 10 && k < 3000) begin
            @(posedge clk); #1;
            k++;
            if (!busy0 && !busy1) idle++;
            else idle = 0;
        end
        check("wait_quiet bound", idle >= 10, 1);
        #1;
    endtask

    task automatic check_rx(input string nm, input int inst, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        logic [7:0] e [6];
        int sz;
        e  = '{b0, b1, b2, b3, b4, b5};
        sz = (inst == 0) ? rx0.size() : rx1.size();
        check({nm, " nbytes"}, sz, n);
        for (int k = 0; k < n && k < sz; k++)
            check({nm, " byte"}, (inst == 0) ? rx0[k] : rx1[k], e[k]);
    endtask

    // Applies a new value, checks the two-edge latency, then measures busy length of both instances
    task automatic launch(input logic [3:0] v, output int n0, output int n1);
        int k = 0;
        count = v;
        @(posedge clk); @(posedge clk); #1;
        check("lat tx0 before E2", tx0, 1'b1);
        check("lat busy0 before E2", busy0, 1'b0);
        @(posedge clk); #1;
        check("lat tx0 at E2", tx0, 1'b0);
        check("lat busy0 at E2", busy0, 1'b1);
        check("lat tx1 at E2", tx1, 1'b0);
        check("lat busy1 at E2", busy1, 1'b1);
        n0 = int'(busy0);
        n1 = int'(busy1);
        while ((busy0 || busy1) && k < 2000) begin
            @(posedge clk); #1;
            n0 += int'(busy0);
            n1 += int'(busy1);
            k++;
        end
        check("launch bound", k < 2000, 1);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n0, n1, k;
        ovc[0] = 0;
        ovc[1] = 0;

        // 1. reset state, then idle at zero
        rst = 1'b1; count = 4'd0;
        repeat (20) @(posedge clk);
        #1;
        check("reset tx0", tx0, 1'b1);
        check("reset busy0", busy0, 1'b0);
        check("reset ov0", ov0, 1'b0);
        check("reset tx1", tx1, 1'b1);
        check("reset busy1", busy1, 1'b0);
        #1;
        rst = 1'b0;
        clear_rx();
        tick(500);
        check("idle0 nbytes", rx0.size(), 0);
        check("idle1 nbytes", rx1.size(), 0);
        check("idle ov0", ovc[0], 0);

        // 2. 0->5: '5' CR LF, busy 3*41 (123) cycles / single byte 41 cycles
        launch(4'd5, n0, n1);
        check("busy0 len nl", n0, 123);
        check("busy1 len no-nl", n1, 41);
        tick(20);
        check_rx("t2 nl",  0, 3, 8'h35, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00);
        check_rx("t2 raw", 1, 1, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // 3. 9->10 gives 'A'; 15->0 wrap gives '0'
        count = 4'd9; wait_quiet();
        clear_rx();
        count = 4'd10; wait_quiet();
        check_rx("t3 A nl",  0, 3, 8'h41, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00);
        check_rx("t3 A raw", 1, 1, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        count = 4'd15; wait_quiet();
        clear_rx();
        count = 4'd0; wait_quiet();
        check_rx("t3 wrap nl",  0, 3, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00);
        check_rx("t3 wrap raw", 1, 1, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // 4. 1, then 2 and 3 during the '1' frame: '1' then '3', one overrun
        clear_rx();
        count = 4'd1; tick(10);
        count = 4'd2; tick(10);
        count = 4'd3; wait_quiet();
        check_rx("t4 nl",  0, 6, 8'h31, 8'h0D, 8'h0A, 8'h33, 8'h0D, 8'h0A);
        check_rx("t4 raw", 1, 2, 8'h31, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
        check("t4 overrun0 pulses", ovc[0], 1);
        check("t4 overrun1 pulses", ovc[1], 1);

        // 5. reset during data bit 3 of '7' (0x37, bit 3 is 0)
        clear_rx();
        count = 4'd7;
        k = 0;
        while (!busy0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5 frame start", busy0, 1'b1);
        repeat (17) @(posedge clk);
        #2;
        check("t5 mid tx0 low", tx0, 1'b0);
        check("t5 mid busy0", busy0, 1'b1);
        rst = 1'b1;
        #1;
        check("t5 async tx0", tx0, 1'b1);
        check("t5 async busy0", busy0, 1'b0);
        check("t5 async tx1", tx1, 1'b1);
        check("t5 async busy1", busy1, 1'b0);
        tick(5);
        rst = 1'b0;
        clear_rx();
        wait_quiet();
        check_rx("t5 resend nl",  0, 3, 8'h37, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00);
        check_rx("t5 resend raw", 1, 1, 8'h37, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        count = 4'd0;
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        clear_rx();
        tick(500);
        check("t5 zero nbytes0", rx0.size(), 0);
        check("t5 zero nbytes1", rx1.size(), 0);

        // 6. 3->12: 'C' alone on the no-newline instance, busy 41 cycles
        count = 4'd3; wait_quiet();
        clear_rx();
        launch(4'd12, n0, n1);
        check("t6 busy1 len", n1, 41);
        check("t6 busy0 len", n0, 123);
        tick(20);
        check_rx("t6 raw", 1, 1, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_rx("t6 nl",  0, 3, 8'h43, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
